// File: rtl/decode_stage.sv
// Registered instruction-decode stage for the 9-bit accumulator ISA.
// Fetch handshake in, one-cycle decoded control out, with halt FSM, illegal flag and retired count.
module decode_stage #(
   parameter int INSTR_W  = 9,
   parameter int REG_W    = 4,
   parameter int ALUOP_W  = 4,
   parameter int ADR_REG  = 4,
   parameter int MATH_REG = 5,
   parameter int CNT_REG  = 7,
   parameter int COUNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               instr_ready,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   output logic [REG_W-1:0]   read_reg0,
   output logic [REG_W-1:0]   read_reg1,
   output logic [REG_W-1:0]   write_reg,
   output logic               write_en,
   output logic               move,
   output logic               mem_to_reg,
   output logic               mem_write,
   output logic               branch,
   output logic               immediate,
   output logic               jump_sign,
   output logic               set_quarter,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         reg_to_mem,
   output logic               halted,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count
);

   localparam int OPC_W = 5;

   localparam logic [REG_W-1:0] ADR  = REG_W'(ADR_REG);
   localparam logic [REG_W-1:0] MATH = REG_W'(MATH_REG);
   localparam logic [REG_W-1:0] CNT  = REG_W'(CNT_REG);

   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_EVU  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_EVL  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_BGTE = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_BLTZ = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_BEZ  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_BE   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(8);

   typedef enum logic [0:0] {ST_RUN, ST_HALTED} state_t;

   typedef struct packed {
      logic [REG_W-1:0]   r0;
      logic [REG_W-1:0]   r1;
      logic [REG_W-1:0]   wr;
      logic               write_en;
      logic               move;
      logic               mem_to_reg;
      logic               mem_write;
      logic               branch;
      logic               immediate;
      logic               jump_sign;
      logic               set_quarter;
      logic [ALUOP_W-1:0] alu_op;
      logic [1:0]         reg_to_mem;
   } ctrl_t;

   state_t              state_reg, state_next;
   ctrl_t               ctrl_reg, ctrl_next, dec;
   logic                valid_reg, valid_next;
   logic                illegal_reg, illegal_next;
   logic [COUNT_W-1:0]  count_reg, count_next;
   logic                dec_halt, dec_illegal;
   logic                accept;
   logic [OPC_W-1:0]    opcode;
   logic [REG_W-1:0]    fld_a, fld_b, fld_q;

   assign opcode = instr_in[INSTR_W-1 -: OPC_W];

   // Operand sub-fields, zero-extended to register-index width.
   genvar gi;
   generate
      for (gi = 0; gi < REG_W; gi++) begin : g_fld
         if (gi < 2) begin : g_ab
            assign fld_a[gi] = instr_in[gi+2];
            assign fld_b[gi] = instr_in[gi];
         end else begin : g_ab_zero
            assign fld_a[gi] = 1'b0;
            assign fld_b[gi] = 1'b0;
         end
         if (gi < 4) begin : g_q
            assign fld_q[gi] = instr_in[gi];
         end else begin : g_q_zero
            assign fld_q[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      dec         = '0;
      dec_halt    = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         5'h00, 5'h01: begin
            dec.r0 = fld_a; dec.r1 = MATH; dec.wr = fld_b; dec.write_en = 1'b1;
            dec.alu_op = (opcode == 5'h01) ? ALU_SUB : ALU_ADD;
         end
         5'h02: begin dec.r0 = fld_a; dec.wr = fld_b; dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h03: begin dec.r0 = fld_a; dec.wr = ADR;   dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h04: begin dec.r0 = ADR;   dec.wr = fld_b; dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h05: begin
            dec.wr = ADR; dec.write_en = 1'b1; dec.immediate = 1'b1; dec.jump_sign = instr_in[0];
         end
         5'h06: begin dec.r0 = fld_q; dec.wr = MATH;  dec.write_en = 1'b1; dec.immediate = 1'b1; end
         5'h07: begin dec.r0 = MATH;  dec.wr = fld_b; dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h08: begin dec.r0 = fld_a; dec.wr = MATH;  dec.write_en = 1'b1; dec.move = 1'b1; end
         // Quarter-set forms: r0 supplies the data, r1 selects which quarter is written.
         5'h09, 5'h0A, 5'h0B: begin
            dec.r0 = (opcode == 5'h0B) ? fld_b : MATH;
            dec.r1 = fld_a;
            dec.wr = (opcode == 5'h09) ? ADR : ((opcode == 5'h0A) ? fld_b : CNT);
            dec.write_en = 1'b1; dec.move = 1'b1; dec.set_quarter = 1'b1;
         end
         5'h0C: begin dec.r0 = CNT;   dec.wr = fld_b; dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h0D: begin dec.r0 = fld_a; dec.wr = CNT;   dec.write_en = 1'b1; dec.move = 1'b1; end
         5'h0E: begin dec.wr = CNT; dec.write_en = 1'b1; dec.immediate = 1'b1; end
         5'h0F, 5'h10, 5'h11, 5'h12, 5'h13: begin
            dec.r0 = fld_a; dec.r1 = fld_b; dec.branch = 1'b1;
            case (opcode)
               5'h0F:   dec.alu_op = ALU_BE;
               5'h10:   dec.alu_op = ALU_BNE;
               5'h11:   dec.alu_op = ALU_BEZ;
               5'h12:   dec.alu_op = ALU_BLTZ;
               default: dec.alu_op = ALU_BGTE;
            endcase
         end
         5'h14, 5'h15: begin
            dec.r0 = fld_a; dec.wr = fld_b; dec.write_en = 1'b1;
            dec.alu_op = (opcode == 5'h14) ? ALU_EVU : ALU_EVL;
         end
         5'h16: begin
            dec.r0 = fld_a; dec.r1 = ADR; dec.wr = fld_b;
            dec.write_en = 1'b1; dec.mem_to_reg = 1'b1; dec.alu_op = ALU_ADD;
         end
         5'h17: begin
            dec.r0 = fld_a; dec.r1 = ADR; dec.mem_write = 1'b1;
            dec.reg_to_mem = fld_b[1:0]; dec.alu_op = ALU_ADD;
         end
         5'h18: begin dec.branch = 1'b1; dec.alu_op = ALU_BE; end
         5'h19: begin dec.wr = fld_b; dec.write_en = 1'b1; dec.immediate = 1'b1; end
         5'h1A: dec_halt = 1'b1;
         default: dec_illegal = 1'b1;
      endcase
   end

   // Halt FSM; also owns the fetch-side ready.
   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      case (state_reg)
         ST_RUN: begin
            instr_ready = !stall && !flush;
            if (instr_valid && instr_ready && dec_halt) begin
               state_next = ST_HALTED;
            end
         end
         default: begin
            instr_ready = 1'b0;
            state_next  = ST_HALTED;
         end
      endcase
   end

   assign accept = instr_valid && instr_ready;

   // Output slot: flush beats stall beats accept; anything else drains to a bubble.
   always_comb begin
      ctrl_next    = ctrl_reg;
      valid_next   = valid_reg;
      illegal_next = illegal_reg;
      if (flush) begin
         ctrl_next    = '0;
         valid_next   = 1'b0;
         illegal_next = 1'b0;
      end else if (stall) begin
         ctrl_next    = ctrl_reg;
      end else if (accept) begin
         ctrl_next    = dec;
         valid_next   = 1'b1;
         illegal_next = dec_illegal;
      end else begin
         ctrl_next    = '0;
         valid_next   = 1'b0;
         illegal_next = 1'b0;
      end
   end

   always_comb begin
      count_next = count_reg;
      if (accept && (count_reg != {COUNT_W{1'b1}})) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_RUN;
         ctrl_reg    <= '0;
         valid_reg   <= 1'b0;
         illegal_reg <= 1'b0;
         count_reg   <= '0;
      end else begin
         state_reg   <= state_next;
         ctrl_reg    <= ctrl_next;
         valid_reg   <= valid_next;
         illegal_reg <= illegal_next;
         count_reg   <= count_next;
      end
   end

   assign out_valid   = valid_reg;
   assign read_reg0   = ctrl_reg.r0;
   assign read_reg1   = ctrl_reg.r1;
   assign write_reg   = ctrl_reg.wr;
   assign write_en    = ctrl_reg.write_en;
   assign move        = ctrl_reg.move;
   assign mem_to_reg  = ctrl_reg.mem_to_reg;
   assign mem_write   = ctrl_reg.mem_write;
   assign branch      = ctrl_reg.branch;
   assign immediate   = ctrl_reg.immediate;
   assign jump_sign   = ctrl_reg.jump_sign;
   assign set_quarter = ctrl_reg.set_quarter;
   assign alu_op      = ctrl_reg.alu_op;
   assign reg_to_mem  = ctrl_reg.reg_to_mem;
   assign halted      = (state_reg == ST_HALTED);
   assign illegal     = illegal_reg;
   assign instr_count = count_reg;

endmodule
